// File: rtl/pool_pkg.sv
// pool_pkg: shared widths, FSM encoding and element record
// for the average-pooling datapath (fetch and accumulate).
package pool_pkg;

  localparam int POOL_ADDR_W = 12;
  localparam int POOL_DATA_W = 32;
  localparam int POOL_DIM_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } pool_state_e;

  typedef struct packed {
    logic [POOL_DATA_W-1:0] data;
    logic                   first;
    logic                   last;
    logic                   map_last;
  } pool_elem_t;

endpackage

// File: rtl/pool_fetch_fifo.sv
// pool_fetch_fifo: 2-entry FIFO of pooling elements plus flags;
// head is presented combinationally and held until popped.
module pool_fetch_fifo
  import pool_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pool_elem_t wdata,
  input  logic       pop,
  output pool_elem_t rdata,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  pool_elem_t mem [2];
  logic       wp;
  logic       rp;

  assign rdata = mem[rp];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pool_window_fetch.sv
// pool_window_fetch: walks pooling windows and streams elements.
// Define POOL_FETCH_PAD_EN to zero-pad partial edge windows.
module pool_window_fetch
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = POOL_ADDR_W,
  parameter int DATA_WIDTH = POOL_DATA_W,
  parameter int DIM_WIDTH  = POOL_DIM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  pool_size,
  input  logic [DIM_WIDTH-1:0]  stride,
  input  logic [DIM_WIDTH-1:0]  dimensions,
  input  logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_map_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int CW = DIM_WIDTH + 2;

  pool_state_e           state;
  logic [DIM_WIDTH-1:0]  k_q, s_q, n_q;
  logic [DIM_WIDTH-1:0]  i_q, j_q;
  logic [CW-1:0]         r0_q, c0_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic fl_v, fl_pad, fl_first, fl_last, fl_ml;

  logic [CW-1:0]         row, col;
  logic [ADDR_WIDTH-1:0] addr;
  logic pad, c_last, r_last;
  logic i_end, j_end;
  logic first_f, last_f, ml_f;
  logic issue, pop, bad_cfg, drained;

  pool_elem_t  fifo_in, fifo_out;
  logic [1:0]  fifo_cnt;
  logic        fifo_full, fifo_empty;

  assign row   = r0_q + CW'(i_q);
  assign col   = c0_q + CW'(j_q);
  assign addr  = base_q + ADDR_WIDTH'(row) * ADDR_WIDTH'(n_q)
               + ADDR_WIDTH'(col);
  assign i_end = (i_q == k_q - DIM_WIDTH'(1));
  assign j_end = (j_q == k_q - DIM_WIDTH'(1));

`ifdef POOL_FETCH_PAD_EN
  assign pad    = (row >= CW'(n_q)) || (col >= CW'(n_q));
  assign c_last = (c0_q + CW'(k_q) >= CW'(n_q));
  assign r_last = (r0_q + CW'(k_q) >= CW'(n_q));
`else
  assign pad    = 1'b0;
  assign c_last = (c0_q + CW'(s_q) + CW'(k_q) > CW'(n_q));
  assign r_last = (r0_q + CW'(s_q) + CW'(k_q) > CW'(n_q));
`endif

  assign first_f = (i_q == '0) && (j_q == '0);
  assign last_f  = i_end && j_end;
  assign ml_f    = last_f && c_last && r_last;

  assign pop = out_valid && out_ready;

  // A same-cycle pop frees a slot, which keeps one beat per cycle.
  assign issue = (state == ST_RUN)
              && (3'(fifo_cnt) + 3'(fl_v) < 3'd2 + 3'(pop))
              && (!fifo_full || pop);

  assign bad_cfg = (pool_size == '0) || (stride == '0)
                || (dimensions == '0) || (pool_size > dimensions);

  assign drained = !fl_v
                && (fifo_empty || (fifo_cnt == 2'd1 && pop));

  assign mem_rd_en   = issue && !pad;
  assign mem_rd_addr = mem_rd_en ? addr : '0;

  assign fifo_in.data     = fl_pad ? '0 : mem_rd_data;
  assign fifo_in.first    = fl_first;
  assign fifo_in.last     = fl_last;
  assign fifo_in.map_last = fl_ml;

  pool_fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fl_v),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_out),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_out.data;
  assign out_first    = fifo_out.first;
  assign out_last     = fifo_out.last;
  assign out_map_last = fifo_out.map_last;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cfg_err  <= 1'b0;
      k_q      <= '0;
      s_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      r0_q     <= '0;
      c0_q     <= '0;
      fl_v     <= 1'b0;
      fl_pad   <= 1'b0;
      fl_first <= 1'b0;
      fl_last  <= 1'b0;
      fl_ml    <= 1'b0;
    end else begin
      fl_v     <= issue;
      fl_pad   <= pad;
      fl_first <= first_f;
      fl_last  <= last_f;
      fl_ml    <= ml_f;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            k_q    <= pool_size;
            s_q    <= stride;
            n_q    <= dimensions;
            base_q <= input_addr;
            i_q    <= '0;
            j_q    <= '0;
            r0_q   <= '0;
            c0_q   <= '0;
            if (bad_cfg) begin
              state   <= ST_DONE;
              cfg_err <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (!j_end) begin
              j_q <= j_q + DIM_WIDTH'(1);
            end else begin
              j_q <= '0;
              if (!i_end) begin
                i_q <= i_q + DIM_WIDTH'(1);
              end else begin
                i_q <= '0;
                if (!c_last) begin
                  c0_q <= c0_q + CW'(s_q);
                end else begin
                  c0_q <= '0;
                  if (!r_last) begin
                    r0_q <= r0_q + CW'(s_q);
                  end else begin
                    r0_q  <= '0;
                    state <= ST_DRAIN;
                  end
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drained) state <= ST_DONE;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          cfg_err <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
